// File: rtl/ballot_pkg.sv
// ballot_pkg: shared FSM state type and width helpers for the ballot collector.
// Default widths N=2, M=2; the helpers derive widths for any N/M.
package ballot_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  localparam int N_DEF      = 2;
  localparam int M_DEF      = 2;
  localparam int NUM_VOTERS = 2 ** M_DEF;
  localparam int BUS_W      = NUM_VOTERS * N_DEF;

  function automatic int num_voters(input int m);
    return 2 ** m;
  endfunction

  function automatic int bus_w(input int n, input int m);
    return (2 ** m) * n;
  endfunction

endpackage

// File: rtl/ballot_mask.sv
// ballot_mask: per-voter seen bits. Ports: clk, rst_n (sync, active low),
// set_idx/set_en mark a voter, clr wipes all bits, query_idx -> hit.
module ballot_mask
  import ballot_pkg::*;
#(
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] set_idx,
  input  logic         set_en,
  input  logic         clr,
  input  logic [M-1:0] query_idx,
  output logic         hit
);

  localparam int NV = num_voters(M);

  logic [NV-1:0] seen;

  // Clear wins over set: the round-closing handshake never coincides
  // with an accept, but the priority keeps the mask clean regardless.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      seen <= '0;
    end else if (set_en) begin
      seen[set_idx] <= 1'b1;
    end
  end

  assign hit = seen[query_idx];

endmodule

// File: rtl/ballot_collector.sv
// ballot_collector: gathers one ballot per voter into a packed vote bus and
// publishes it with valid/ready. Ports: clk, rst_n, in_valid/in_ready,
// in_voter, in_vote, out_valid/out_ready, out_vote, dup_err, count.
// Option BALLOT_DUP_CHECK_EN enables duplicate-voter rejection.
module ballot_collector
  import ballot_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [M-1:0]          in_voter,
  input  logic [N-1:0]          in_vote,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [bus_w(N,M)-1:0] out_vote,
  output logic                  dup_err,
  output logic [M:0]            count
);

  localparam int NV = num_voters(M);
  localparam logic [M:0] LAST = (M+1)'(NV - 1);

  state_t state, state_nxt;

  logic accept;
  logic fresh;
  logic done;

  assign accept = in_valid & in_ready;
  assign done   = out_valid & out_ready;

`ifdef BALLOT_DUP_CHECK_EN
  logic hit;

  ballot_mask #(.M(M)) u_mask (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_idx   (in_voter),
    .set_en    (fresh),
    .clr       (done),
    .query_idx (in_voter),
    .hit       (hit)
  );

  assign fresh = accept & ~hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dup_err <= 1'b0;
    end else begin
      dup_err <= accept & hit;
    end
  end
`else
  assign fresh   = accept;
  assign dup_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (fresh && count == LAST) state_nxt = PUBLISH;
      PUBLISH: if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == PUBLISH);
  end

  // Writes only happen in COLLECT, so out_vote is frozen while publishing.
  always_ff @(posedge clk) begin
    if (!rst_n || done) begin
      count    <= '0;
      out_vote <= '0;
    end else if (fresh) begin
      count                  <= count + (M+1)'(1);
      out_vote[in_voter*N +: N] <= in_vote;
    end
  end

endmodule
